// File: rtl/wishbone_multi_arbiter.sv
// Wishbone N-master to single-slave arbiter with fixed-priority or round-robin
// selection, no preemption, and an optional slave-response watchdog.
module wishbone_multi_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 24,
    parameter int SEL_W     = 2,
    parameter int MODE      = 0,
    parameter int TIMEOUT   = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_MASTERS-1:0]          m_cyc,
    input  logic [N_MASTERS-1:0]          m_stb,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_adr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_o_dat,
    input  logic [N_MASTERS*SEL_W-1:0]    m_sel,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_err,
    output logic [N_MASTERS-1:0]          m_rty,
    output logic [DATA_W-1:0]             m_i_dat,
    output logic                          wb_cyc,
    output logic                          wb_stb,
    output logic                          wb_we,
    output logic [ADDR_W-1:0]             wb_adr,
    output logic [DATA_W-1:0]             wb_o_dat,
    output logic [SEL_W-1:0]              wb_sel,
    input  logic [DATA_W-1:0]             wb_i_dat,
    input  logic                          wb_ack,
    input  logic                          wb_err,
    input  logic                          wb_rty,
    output logic [N_MASTERS-1:0]          o_grant,
    output logic                          o_timeout
);

    localparam int OW = $clog2(N_MASTERS);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          last_q, last_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;

    logic                   owned;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   arb_en;
    logic                   found;
    logic [OW-1:0]          winner;
    logic                   wd_fire;
    logic                   resp_en;
    int                     idx;

    assign owned     = (state_q == OWNED);
    assign owner_cyc = m_cyc[owner_q];
    assign owner_stb = m_stb[owner_q];
    assign arb_en    = !owned || !owner_cyc;

    // Loops run from the far end so the last hit written is the highest priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        if (MODE == 0) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (m_cyc[i]) begin
                    found  = 1'b1;
                    winner = OW'(i);
                end
            end
        end else begin
            for (int i = N_MASTERS; i >= 1; i--) begin
                idx = int'(last_q) + i;
                if (idx >= N_MASTERS) idx = idx - N_MASTERS;
                if (m_cyc[idx[OW-1:0]]) begin
                    found  = 1'b1;
                    winner = idx[OW-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        if (arb_en) begin
            if (found) begin
                state_d         = OWNED;
                owner_d         = winner;
                last_d          = winner;
                grant_d         = '0;
                grant_d[winner] = 1'b1;
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end
    end

    // last_q resets to the top index so round-robin starts its search at master 0.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(N_MASTERS - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] wd_cnt_q, wd_cnt_d;
            logic          pending;

            // An ownership change always passes through a wb_cyc=0 cycle, which clears the count.
            always_comb begin
                pending  = wb_cyc && owner_stb && !(wb_ack || wb_err || wb_rty);
                wd_cnt_d = '0;
                if (pending && !wd_fire) wd_cnt_d = wd_cnt_q + 1'b1;
            end

            assign wd_fire = wb_cyc && owner_stb && (wd_cnt_q == CW'(TIMEOUT - 1));

            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) wd_cnt_q <= '0;
                else        wd_cnt_q <= wd_cnt_d;
            end
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    assign o_timeout = wd_fire;
    assign o_grant   = grant_q;

    assign wb_cyc   = owned && owner_cyc;
    assign wb_stb   = owned && owner_stb && !wd_fire;
    assign wb_we    = owned && m_we[owner_q];
    assign wb_adr   = owned ? m_adr[owner_q*ADDR_W +: ADDR_W]   : '0;
    assign wb_o_dat = owned ? m_o_dat[owner_q*DATA_W +: DATA_W] : '0;
    assign wb_sel   = owned ? m_sel[owner_q*SEL_W +: SEL_W]     : '0;

    // A watchdog error replaces whatever the slave answered in that cycle.
    assign resp_en = owned && !wd_fire;
    assign m_ack   = (resp_en && wb_ack) ? grant_q : '0;
    assign m_rty   = (resp_en && wb_rty) ? grant_q : '0;
    assign m_err   = ((resp_en && wb_err) || wd_fire) ? grant_q : '0;
    assign m_i_dat = wb_i_dat;

endmodule

// File: doc/wishbone_multi_arbiter.md
WISHBONE_MULTI_ARBITER -- requirements
Module: wishbone_multi_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 2: number of Wishbone masters, legal range >= 2.
REQ-002 Parameter DATA_W, default 16: data width.
REQ-003 Parameter ADDR_W, default 24: address width.
REQ-004 Parameter SEL_W, default 2: byte-select width.
REQ-005 Parameter MODE, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
REQ-006 Parameter TIMEOUT, default 0: slave-response watchdog in cycles; 0 disables the watchdog.
REQ-007 i_clk  in  1  single clock; all state changes on the rising edge.
REQ-008 i_rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-009 m_cyc, m_stb, m_we  in  N_MASTERS each  per-master cyc, stb and we.
REQ-010 m_adr  in  N_MASTERS*ADDR_W  per-master address, flattened; master k occupies bits [k*ADDR_W +: ADDR_W].
REQ-011 m_o_dat  in  N_MASTERS*DATA_W  per-master write data, flattened in the same way.
REQ-012 m_sel  in  N_MASTERS*SEL_W  per-master byte select, flattened in the same way.
REQ-013 m_ack, m_err, m_rty  out  N_MASTERS each  per-master responses.
REQ-014 m_i_dat  out  DATA_W  read data broadcast to all masters.
REQ-015 wb_cyc, wb_stb, wb_we  out  1 each  slave-side bus control.
REQ-016 wb_adr (ADDR_W), wb_o_dat (DATA_W), wb_sel (SEL_W)  out  slave-side address, write data and byte select.
REQ-017 wb_i_dat (DATA_W), wb_ack, wb_err, wb_rty (1 each)  in  slave-side read data and responses.
REQ-018 o_grant  out  N_MASTERS  one-hot registered owner; all zero when the bus is idle.
REQ-019 o_timeout  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-020 The block SHALL have two states. IDLE: no owner. OWNED: one registered owner.
REQ-021 Arbitration SHALL be evaluated in every cycle where the state is IDLE, or where the state is OWNED and m_cyc of the owner is 0.
- The winner is registered on the clock edge.
- The winner drives the bus from the next cycle, so arbitration latency is 1 cycle.
- After any release, the bus is idle for at least 1 cycle.
REQ-022 In OWNED, ownership SHALL be held while m_cyc[owner]=1; requests from other masters are ignored, with no preemption.
REQ-023 When the owner drops m_cyc and no master requests, the state SHALL become IDLE and o_grant SHALL become 0.
REQ-024 MODE=0: the lowest-index master with m_cyc=1 SHALL win.
REQ-025 MODE=1: the search SHALL start at last_owner+1, wrap from N_MASTERS-1 to 0, and take the first requester.
- last_owner updates only when a grant is made.
- Any persistent requester is granted within N_MASTERS-1 intervening grants.
REQ-026 wb_cyc SHALL equal OWNED & m_cyc[owner].
- wb_stb, wb_we, wb_adr, wb_o_dat and wb_sel mux the owner's signals.
- In IDLE, all slave-side outputs SHALL be 0.
REQ-027 wb_ack, wb_err and wb_rty SHALL route combinationally to the owner's bit only; all other master response bits are 0.
REQ-028 m_i_dat SHALL equal wb_i_dat unconditionally.
REQ-029 Watchdog (TIMEOUT>0), counter width $clog2(TIMEOUT+1):
- Increments each cycle with wb_cyc & wb_stb & ~(wb_ack|wb_err|wb_rty).
- Clears on any slave response, on an ownership change, and when wb_stb=0.
REQ-030 When the counter reaches TIMEOUT, the block SHALL, for exactly that cycle:
- assert m_err[owner]=1 and o_timeout=1;
- force wb_stb=0 and ignore slave responses;
- clear the counter on the next edge.
Ownership is kept.
REQ-031 A slave response in the same cycle the counter reaches TIMEOUT SHALL be discarded in favour of the watchdog error.
REQ-032 With TIMEOUT=0, the counter SHALL be absent and o_timeout SHALL be tied to 0.
REQ-033 Requests that arrive in the same cycle as a release SHALL take part in that cycle's arbitration.

Reset
REQ-034 While i_rst=0, the block SHALL asynchronously clear:
- the state to IDLE and o_grant to 0;
- the watchdog counter to 0 and o_timeout to 0;
- last_owner to N_MASTERS-1, so master 0 is favoured first in round-robin.
REQ-035 Consequently wb_cyc, wb_stb, m_ack, m_err and m_rty SHALL be 0 during reset, including when reset is applied mid-transaction.
REQ-036 The first arbitration SHALL occur on the first rising edge with i_rst=1.

Verification
REQ-037 N=3, MODE=0: m_cyc=3'b110 held -> o_grant=3'b010 one cycle later. m_cyc[1] drops -> idle cycle, then o_grant=3'b100.
REQ-038 N=3, MODE=1: all three m_cyc held high, each owner drops cyc after 2 cycles -> grant order 0,1,2,0, one idle cycle between grants.
REQ-039 Owner master 1, slave wb_ack=1 -> m_ack=3'b010 in the same cycle; m_i_dat equals wb_i_dat.
REQ-040 TIMEOUT=4, owner strobes and slave never responds -> m_err[owner] and o_timeout=1 on the 4th strobe cycle with wb_stb=0 that cycle. Next cycle the counter is 0 and the owner is retained.
REQ-041 i_rst=0 mid-transfer while owner is master 2 -> wb_cyc=0 and o_grant=0 immediately. After release, with all masters requesting in MODE=1, master 0 is granted first.
